axi_lite_write_slave: RTL
=========================

# axi_lite_write_slave

AXI4-Lite write-channel responder: the subordinate end of the write path whose manager side is driven by the write user port (write_en / write_addr_in / write_data_in / strobe_in / write_done). It accepts AW and W beats in any order, commits byte-strobed writes into an internal register bank, and returns a B response. The register bank is exposed through a combinational read port for the read-side subordinate and for the bench.

## Interface

- WIDTH_ADDR, 32: AW address width (`WIDTH_ADDR from top_define.svh).
- WIDTH_DATA, 32: data width (`WIDTH_DATA); fixed at 32, with 4 strobe bits.
- NUM_REGS, 16: number of 32-bit registers; power of two, at least 2.

Ports:

- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- awaddr  in  WIDTH_ADDR  write address.
- awvalid  in  1  / awready  out  1  AW handshake.
- wdata  in  WIDTH_DATA  write data.
- wstrb  in  4  byte strobes; bit i covers wdata[8i+7:8i].
- wvalid  in  1  / wready  out  1  W handshake.
- bresp  out  2  00 = OKAY, 10 = SLVERR.
- bvalid  out  1  / bready  in  1  B handshake.
- rd_index  in  $clog2(NUM_REGS)  register select for the read port.
- rd_data  out  WIDTH_DATA  regs[rd_index], combinational.

## Operation

- A handshake occurs on a posedge where valid && ready for that channel.
- AW holding buffer: aw_full, aw_addr. W holding buffer: w_full, w_data, w_strb. Each buffer captures on its own handshake, in either order, at most once per transaction.
- awready = !aw_full && state==IDLE, and wready = !w_full && state==IDLE. Both are registered outputs.
- FSM:
  - IDLE: collect beats. When aw_full && w_full, the next edge commits the write, sets bvalid=1, and moves to RESP.
  - RESP: hold bvalid and bresp stable until bready. On the B handshake edge: bvalid=0, both buffers cleared, awready=wready=1, and the state returns to IDLE.
- Decode: index = aw_addr[2 +: $clog2(NUM_REGS)]. aw_addr[1:0] is ignored.
- Range check: if aw_addr >= NUM_REGS*4, no register changes and bresp=10. Otherwise bresp=00.
- Strobe merge: for each byte i with w_strb[i]=1, regs[index][8i+7:8i] takes w_data[8i+7:8i]. Other bytes keep their value. wstrb=0000 is a legal no-op write and returns OKAY.
- Only one transaction is outstanding at a time. No pipelining of a second AW/W while in RESP.

## Timing

- Reset values: awready=1, wready=1, bvalid=0, bresp=00, both buffers empty, state IDLE, all regs 0.
- Reset asserted mid-transaction (buffer half full, or in RESP) discards the transaction: no register write, bvalid drops on that edge, and all outputs take their reset values on that edge.
- Simultaneous AW and W handshake at edge k:
  - awready=wready=0 after k.
  - Register updated and bvalid=1 after edge k+1.
- Staggered handshakes: the commit happens one edge after the later handshake. The ready of the earlier channel is low from its handshake until the B handshake.
- bready held high: the B handshake is at edge k+2, and both readies are 1 after k+2. The minimum transaction spacing is 3 cycles.
- bvalid stays asserted and bresp is stable while bready=0, for any number of cycles.
- rd_data reflects a committed write in the cycle after the commit edge.
- awvalid or wvalid asserted while the matching ready is low is not captured. The manager must hold it per AXI rules.

## Test plan

- Reset then full write: awaddr=0x8, wdata=0xDEADBEEF, wstrb=1111, AW/W together, bready=1 → bvalid one cycle after the handshake, bresp=00, rd_index=2 gives 0xDEADBEEF, awready=wready=1 two edges after the handshake.
- Partial strobe: regs[3]=0x11223344, then write 0xAABBCCDD with wstrb=0101 to 0xC → rd_data=0x11BB33DD, bresp=00.
- Out of order: W (0x12345678, 1111) accepted 3 cycles before AW 0x4 → wready low after the W beat, commit one edge after AW, regs[1]=0x12345678.
- Out of range: awaddr=0x40 (NUM_REGS=16), data 0xFFFFFFFF → bresp=10, all 16 regs unchanged.
- Backpressure: bready=0 for 5 cycles after bvalid → bvalid=1 and bresp stable for all 5 cycles; awready=wready=0 throughout; a new awvalid is not accepted until the B handshake.
- Reset mid-transaction: AW accepted, reset pulsed before W → awready=1, bvalid=0, regs all 0; a subsequent full write completes normally.

Source files
------------

// File: rtl/axi_lite_write_slave.sv
// AXI4-Lite write-channel subordinate: accepts AW/W beats in any order, commits
// byte-strobed writes into a register bank, and returns a B response.
module axi_lite_write_slave #(
   parameter int unsigned WIDTH_ADDR = 32,
   parameter int unsigned WIDTH_DATA = 32,
   parameter int unsigned NUM_REGS   = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [WIDTH_ADDR-1:0]       awaddr,
   input  logic                        awvalid,
   output logic                        awready,
   input  logic [WIDTH_DATA-1:0]       wdata,
   input  logic [3:0]                  wstrb,
   input  logic                        wvalid,
   output logic                        wready,
   output logic [1:0]                  bresp,
   output logic                        bvalid,
   input  logic                        bready,
   input  logic [$clog2(NUM_REGS)-1:0] rd_index,
   output logic [WIDTH_DATA-1:0]       rd_data
);

   localparam int unsigned IDX_W    = $clog2(NUM_REGS);
   localparam int unsigned NUM_STRB = 4;
   localparam int unsigned REG_SPAN = NUM_REGS * 4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {IDLE, RESP} state_t;

   state_t                  state, state_d;
   logic                    aw_full, aw_full_d;
   logic [WIDTH_ADDR-1:0]   aw_addr, aw_addr_d;
   logic                    w_full, w_full_d;
   logic [WIDTH_DATA-1:0]   w_data, w_data_d;
   logic [3:0]              w_strb, w_strb_d;
   logic                    awready_d, wready_d, bvalid_d;
   logic [1:0]              bresp_d;
   logic                    commit_c;
   logic                    in_range_c;
   logic [IDX_W-1:0]        wr_idx_c;
   logic [WIDTH_DATA-1:0]   regs [NUM_REGS];

   assign in_range_c = aw_addr < WIDTH_ADDR'(REG_SPAN);
   assign wr_idx_c   = aw_addr[2 +: IDX_W];
   assign rd_data    = regs[rd_index];

   // Next-state, buffer capture and registered-output computation
   always_comb begin
      state_d   = state;
      aw_full_d = aw_full;
      aw_addr_d = aw_addr;
      w_full_d  = w_full;
      w_data_d  = w_data;
      w_strb_d  = w_strb;
      bvalid_d  = bvalid;
      bresp_d   = bresp;
      commit_c  = 1'b0;

      case (state)
         IDLE: begin
            if (awvalid && awready) begin
               aw_full_d = 1'b1;
               aw_addr_d = awaddr;
            end
            if (wvalid && wready) begin
               w_full_d = 1'b1;
               w_data_d = wdata;
               w_strb_d = wstrb;
            end
            if (aw_full && w_full) begin
               commit_c = 1'b1;
               bvalid_d = 1'b1;
               bresp_d  = in_range_c ? RESP_OKAY : RESP_SLVERR;
               state_d  = RESP;
            end
         end
         RESP: begin
            if (bready) begin
               bvalid_d  = 1'b0;
               aw_full_d = 1'b0;
               w_full_d  = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Readies follow the next buffer/state so they are registered yet cycle-accurate
      awready_d = !aw_full_d && (state_d == IDLE);
      wready_d  = !w_full_d  && (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         aw_full <= 1'b0;
         aw_addr <= '0;
         w_full  <= 1'b0;
         w_data  <= '0;
         w_strb  <= '0;
         awready <= 1'b1;
         wready  <= 1'b1;
         bvalid  <= 1'b0;
         bresp   <= RESP_OKAY;
      end else begin
         state   <= state_d;
         aw_full <= aw_full_d;
         aw_addr <= aw_addr_d;
         w_full  <= w_full_d;
         w_data  <= w_data_d;
         w_strb  <= w_strb_d;
         awready <= awready_d;
         wready  <= wready_d;
         bvalid  <= bvalid_d;
         bresp   <= bresp_d;
      end
   end

   // Register bank with byte-lane merge on commit
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
      end else if (commit_c && in_range_c) begin
         for (int b = 0; b < int'(NUM_STRB); b++) begin
            if (w_strb[b]) regs[wr_idx_c][8*b +: 8] <= w_data[8*b +: 8];
         end
      end
   end

endmodule
